// File: rtl/victim_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : victim_cache_ctrl
// Function : fully-associative victim cache between L1 and memory, with
//            true-LRU replacement, dirty write-back and a flush sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module victim_cache_ctrl #(
    parameter int ENTRIES = 8,
    parameter int ADDR_W  = 16,
    parameter int LINE_W  = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              up_read,
    input  logic              up_write,
    input  logic              up_dirty,
    input  logic [ADDR_W-1:0] up_address,
    input  logic [LINE_W-1:0] up_wdata,
    output logic [LINE_W-1:0] up_rdata,
    output logic              up_resp,
    output logic              dn_read,
    output logic              dn_write,
    output logic [ADDR_W-1:0] dn_address,
    output logic [LINE_W-1:0] dn_wdata,
    input  logic [LINE_W-1:0] dn_rdata,
    input  logic              dn_resp,
    input  logic              flush_req,
    output logic              flush_done
);

    localparam int               IDX_W  = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(ENTRIES - 1);
    localparam logic [IDX_W-1:0] C_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOOKUP     = 3'd1,
        S_WRITEBACK  = 3'd2,
        S_FILL       = 3'd3,
        S_RESPOND    = 3'd4,
        S_FLUSH_SCAN = 3'd5,
        S_FLUSH_WB   = 3'd6,
        S_FLUSH_DONE = 3'd7
    } state_t;

    state_t r_state, w_state_nxt;

    logic [ENTRIES-1:0] r_valid, r_dirty;
    logic [ADDR_W-1:0]  r_addr [ENTRIES];
    logic [LINE_W-1:0]  r_data [ENTRIES];
    logic [IDX_W-1:0]   r_age  [ENTRIES];

    logic              r_req_write, r_req_dirty;
    logic [ADDR_W-1:0] r_req_addr, r_dn_addr;
    logic [LINE_W-1:0] r_req_data, r_rdata, r_dn_wdata;
    logic [IDX_W-1:0]  r_idx, r_scan;

    logic             w_hit, w_free, w_victim_dirty, w_wr_hit, w_install, w_touch;
    logic [IDX_W-1:0] w_hit_idx, w_free_idx, w_lru_idx, w_victim_idx;
    logic [IDX_W-1:0] w_install_idx, w_touch_idx;

    // Descending scan leaves the lowest matching index in each result.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        w_lru_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_addr[i] == r_req_addr)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
            if (!r_valid[i]) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (r_age[i] == C_LAST) begin
                w_lru_idx = IDX_W'(i);
            end
        end
    end

    assign w_victim_idx   = w_free ? w_free_idx : w_lru_idx;
    assign w_victim_dirty = r_valid[w_victim_idx] & r_dirty[w_victim_idx];

    assign w_wr_hit      = (r_state == S_LOOKUP) && r_req_write && w_hit;
    assign w_install     = ((r_state == S_LOOKUP) && r_req_write && !w_hit && !w_victim_dirty)
                         || ((r_state == S_WRITEBACK) && dn_resp);
    assign w_install_idx = (r_state == S_WRITEBACK) ? r_idx : w_victim_idx;
    assign w_touch       = w_wr_hit || w_install;
    assign w_touch_idx   = w_wr_hit ? w_hit_idx : w_install_idx;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (flush_req)                 w_state_nxt = S_FLUSH_SCAN;
                else if (up_write || up_read)  w_state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (r_req_write)
                    w_state_nxt = (!w_hit && w_victim_dirty) ? S_WRITEBACK : S_RESPOND;
                else
                    w_state_nxt = w_hit ? S_RESPOND : S_FILL;
            end
            S_WRITEBACK:  if (dn_resp) w_state_nxt = S_RESPOND;
            S_FILL:       if (dn_resp) w_state_nxt = S_RESPOND;
            S_RESPOND:    w_state_nxt = S_IDLE;
            S_FLUSH_SCAN: begin
                if (r_valid[r_scan] && r_dirty[r_scan]) w_state_nxt = S_FLUSH_WB;
                else if (r_scan == C_LAST)              w_state_nxt = S_FLUSH_DONE;
            end
            S_FLUSH_WB: begin
                if (dn_resp) w_state_nxt = (r_scan == C_LAST) ? S_FLUSH_DONE : S_FLUSH_SCAN;
            end
            S_FLUSH_DONE: w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid     <= '0;
            r_dirty     <= '0;
            for (int i = 0; i < ENTRIES; i++) r_age[i] <= IDX_W'(i);
            r_req_write <= 1'b0;
            r_req_dirty <= 1'b0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
            r_idx       <= '0;
            r_scan      <= '0;
            r_rdata     <= '0;
            r_dn_addr   <= '0;
            r_dn_wdata  <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_scan      <= '0;
                r_req_write <= up_write;
                r_req_dirty <= up_dirty;
                r_req_addr  <= up_address;
                r_req_data  <= up_wdata;
            end
            if (w_touch) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (IDX_W'(i) == w_touch_idx)            r_age[i] <= '0;
                    else if (r_age[i] < r_age[w_touch_idx])  r_age[i] <= r_age[i] + C_ONE;
                end
            end
            if (w_install) begin
                r_valid[w_install_idx] <= 1'b1;
                r_dirty[w_install_idx] <= r_req_dirty;
            end
            if (w_wr_hit) r_dirty[w_hit_idx] <= r_dirty[w_hit_idx] | r_req_dirty;
            case (r_state)
                S_LOOKUP: begin
                    if (!r_req_write) begin
                        if (w_hit) begin
                            r_rdata            <= r_data[w_hit_idx];
                            r_valid[w_hit_idx] <= 1'b0;
                            r_dirty[w_hit_idx] <= 1'b0;
                        end else begin
                            r_dn_addr <= r_req_addr;
                        end
                    end else if (!w_hit) begin
                        r_idx      <= w_victim_idx;
                        r_dn_addr  <= r_addr[w_victim_idx];
                        r_dn_wdata <= r_data[w_victim_idx];
                    end
                end
                S_FILL: if (dn_resp) r_rdata <= dn_rdata;
                S_FLUSH_SCAN: begin
                    if (r_valid[r_scan] && r_dirty[r_scan]) begin
                        r_dn_addr  <= r_addr[r_scan];
                        r_dn_wdata <= r_data[r_scan];
                    end else begin
                        r_valid[r_scan] <= 1'b0;
                        r_dirty[r_scan] <= 1'b0;
                        r_scan          <= r_scan + C_ONE;
                    end
                end
                S_FLUSH_WB: begin
                    if (dn_resp) begin
                        r_valid[r_scan] <= 1'b0;
                        r_dirty[r_scan] <= 1'b0;
                        r_scan          <= r_scan + C_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage needs no reset: every read of it is qualified by r_valid.
    always_ff @(posedge clk) begin
        if (w_install) begin
            r_addr[w_install_idx] <= r_req_addr;
            r_data[w_install_idx] <= r_req_data;
        end else if (w_wr_hit) begin
            r_data[w_hit_idx] <= r_req_data;
        end
    end

    assign up_resp    = (r_state == S_RESPOND);
    assign flush_done = (r_state == S_FLUSH_DONE);
    assign dn_read    = (r_state == S_FILL);
    assign dn_write   = (r_state == S_WRITEBACK) || (r_state == S_FLUSH_WB);
    assign up_rdata   = r_rdata;
    assign dn_address = r_dn_addr;
    assign dn_wdata   = r_dn_wdata;

endmodule
`default_nettype wire

// File: tb/tb_victim_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_victim_cache_ctrl
// Function : directed plus randomized bench for victim_cache_ctrl against a
//            recency-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_victim_cache_ctrl;

    localparam int E      = 8;
    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              up_read, up_write, up_dirty;
    logic [ADDR_W-1:0] up_address;
    logic [LINE_W-1:0] up_wdata, up_rdata;
    logic              up_resp;
    logic              dn_read, dn_write;
    logic [ADDR_W-1:0] dn_address;
    logic [LINE_W-1:0] dn_wdata, dn_rdata;
    logic              dn_resp, flush_req, flush_done;

    int n_cmp = 0;
    int n_err = 0;

    bit                m_valid [E];
    bit                m_dirty [E];
    logic [ADDR_W-1:0] m_addr  [E];
    logic [LINE_W-1:0] m_data  [E];
    int                lru_q   [$];

    victim_cache_ctrl #(.ENTRIES(E), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .up_read    (up_read),
        .up_write   (up_write),
        .up_dirty   (up_dirty),
        .up_address (up_address),
        .up_wdata   (up_wdata),
        .up_rdata   (up_rdata),
        .up_resp    (up_resp),
        .dn_read    (dn_read),
        .dn_write   (dn_write),
        .dn_address (dn_address),
        .dn_wdata   (dn_wdata),
        .dn_rdata   (dn_rdata),
        .dn_resp    (dn_resp),
        .flush_req  (flush_req),
        .flush_done (flush_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                         input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] pat(input logic [3:0] n);
        return {(LINE_W/4){n}};
    endfunction

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] r;
        for (int k = 0; k < LINE_W/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void model_reset();
        lru_q = {};
        for (int i = 0; i < E; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            lru_q.push_back(i);
        end
    endfunction

    function automatic int find_hit(input logic [ADDR_W-1:0] a);
        for (int i = 0; i < E; i++) if (m_valid[i] && m_addr[i] == a) return i;
        return -1;
    endfunction

    function automatic void touch(input int idx);
        for (int k = 0; k < lru_q.size(); k++) begin
            if (lru_q[k] == idx) begin
                lru_q.delete(k);
                break;
            end
        end
        lru_q.push_front(idx);
    endfunction

    function automatic int pick_victim();
        for (int i = 0; i < E; i++) if (!m_valid[i]) return i;
        return lru_q[lru_q.size()-1];
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; up_read = 1'b0; up_write = 1'b0; up_dirty = 1'b0;
        up_address = '0; up_wdata = '0; dn_rdata = '0; dn_resp = 1'b0; flush_req = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic txn(input bit wr, input bit both, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] d, input bit dty, input int lat,
                       input logic [LINE_W-1:0] ret);
        int h, v, exp_cyc, resp_cyc, dn_c;
        bit exp_wb, exp_fill, got, saw_wr, saw_rd, dn_ok;
        logic [ADDR_W-1:0] exp_addr;
        logic [LINE_W-1:0] exp_wdata, exp_rdata, rdata_obs;

        h = find_hit(a);
        exp_wb = 1'b0; exp_fill = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
        if (wr) begin
            if (h >= 0) begin
                m_data[h]  = d;
                m_dirty[h] = m_dirty[h] | dty;
                touch(h);
            end else begin
                v = pick_victim();
                if (m_valid[v] && m_dirty[v]) begin
                    exp_wb = 1'b1; exp_addr = m_addr[v]; exp_wdata = m_data[v];
                end
                m_valid[v] = 1'b1; m_dirty[v] = dty; m_addr[v] = a; m_data[v] = d;
                touch(v);
            end
        end else if (h >= 0) begin
            exp_rdata = m_data[h]; m_valid[h] = 1'b0; m_dirty[h] = 1'b0;
        end else begin
            exp_fill = 1'b1; exp_addr = a; exp_rdata = ret;
        end
        exp_cyc = (exp_wb || exp_fill) ? 2 + lat : 2;

        @(negedge clk);
        check("resp_single_pulse", up_resp, 1'b0);
        up_write = wr; up_read = !wr || both; up_address = a; up_wdata = d; up_dirty = dty;
        got = 1'b0; saw_wr = 1'b0; saw_rd = 1'b0; dn_ok = 1'b1; dn_c = 0; resp_cyc = 0;
        rdata_obs = '0;
        for (int c = 1; c <= 200 && !got; c++) begin
            @(negedge clk);
            dn_resp = 1'b0;
            if (up_resp) begin
                got = 1'b1; resp_cyc = c; rdata_obs = up_rdata;
                if (wr) begin
                    up_write = 1'b0;
                    if (!both) up_read = 1'b0;
                end else begin
                    up_read = 1'b0;
                end
            end else if (dn_read || dn_write) begin
                dn_c++;
                if (dn_read)  saw_rd = 1'b1;
                if (dn_write) saw_wr = 1'b1;
                if (dn_address !== exp_addr || (dn_write && dn_wdata !== exp_wdata)) dn_ok = 1'b0;
                if (dn_c == lat) begin
                    dn_resp = 1'b1; dn_rdata = ret;
                end
            end
        end
        check("resp_seen", got, 1'b1);
        check("resp_cycle", resp_cyc, exp_cyc);
        check("dn_write_used", saw_wr, exp_wb);
        check("dn_read_used", saw_rd, exp_fill);
        if (exp_wb || exp_fill) begin
            check("dn_addr_data_stable", dn_ok, 1'b1);
            check("dn_hold_cycles", dn_c, lat);
        end
        if (!wr) check("up_rdata", rdata_obs, exp_rdata);
    endtask

    task automatic do_flush(input bit chk_time);
        logic [ADDR_W-1:0] ea [$];
        logic [LINE_W-1:0] ed [$];
        int wb_n, dn_c, cur_lat, done_n, done_c;
        bit ok, fin;
        for (int i = 0; i < E; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                ea.push_back(m_addr[i]);
                ed.push_back(m_data[i]);
            end
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
        end
        @(negedge clk);
        check("flush_idle_done", flush_done, 1'b0);
        flush_req = 1'b1;
        wb_n = 0; dn_c = 0; done_n = 0; done_c = 0; ok = 1'b1; fin = 1'b0;
        cur_lat = $urandom_range(1, 4);
        for (int c = 1; c <= 400 && !fin; c++) begin
            @(negedge clk);
            dn_resp = 1'b0;
            if (dn_read || up_resp) ok = 1'b0;
            if (flush_done) begin
                done_n++; done_c = c; flush_req = 1'b0; fin = 1'b1;
            end else if (dn_write) begin
                if (wb_n >= ea.size()) ok = 1'b0;
                else if (dn_address !== ea[wb_n] || dn_wdata !== ed[wb_n]) ok = 1'b0;
                dn_c++;
                if (dn_c == cur_lat) begin
                    dn_resp = 1'b1; wb_n++; dn_c = 0; cur_lat = $urandom_range(1, 4);
                end
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (flush_done) done_n++;
        end
        check("flush_done_pulses", done_n, 1);
        check("flush_wb_count", wb_n, ea.size());
        check("flush_wb_order", ok, 1'b1);
        if (chk_time) check("flush_empty_cycles", done_c, E + 1);
    endtask

    initial begin
        bit seen;
        int op;
        logic [ADDR_W-1:0] a;

        do_reset();
        check("rst_up_resp", up_resp, 1'b0);
        check("rst_flush_done", flush_done, 1'b0);
        check("rst_dn_read", dn_read, 1'b0);
        check("rst_dn_write", dn_write, 1'b0);
        check("rst_up_rdata", up_rdata, {LINE_W{1'b0}});
        check("rst_dn_address", dn_address, {ADDR_W{1'b0}});
        check("rst_dn_wdata", dn_wdata, {LINE_W{1'b0}});

        for (int i = 0; i < 4; i++)
            txn(1, 0, ADDR_W'(16'h0010 * (i + 1)), pat(4'(4'hA + i)), 0, 1, '0);
        txn(0, 0, 16'h0020, '0, 0, 1, '0);
        txn(1, 0, 16'h0050, rnd_line(), 0, 1, '0);
        txn(0, 0, 16'h7FF0, '0, 0, 5, {(LINE_W/16){16'h1234}});
        txn(0, 0, 16'h0010, '0, 0, 1, '0);

        do_reset();
        for (int i = 0; i < 8; i++)
            txn(1, 0, ADDR_W'(16'h0100 * (i + 1)), rnd_line(), 1, 1, '0);
        txn(1, 0, 16'h0100, rnd_line(), 0, 1, '0);
        txn(1, 0, 16'h0900, rnd_line(), 1, 3, '0);
        txn(0, 0, 16'h0900, '0, 0, 1, '0);
        txn(0, 0, 16'h0200, '0, 0, 2, rnd_line());

        do_reset();
        for (int i = 0; i < 8; i++)
            txn(1, 0, ADDR_W'(16'h1000 + 16'h0010 * i), rnd_line(), (i == 2 || i == 5), 1, '0);
        do_flush(0);
        txn(0, 0, 16'h1020, '0, 0, 2, rnd_line());
        do_flush(1);

        txn(1, 1, 16'h2000, rnd_line(), 1, 1, '0);
        txn(0, 0, 16'h2000, '0, 0, 1, '0);

        do_reset();
        for (int i = 0; i < 8; i++)
            txn(1, 0, ADDR_W'(16'h0A00 + 16'h0010 * i), rnd_line(), 1, 1, '0);
        @(negedge clk);
        up_write = 1'b1; up_address = 16'h0B00; up_wdata = rnd_line(); up_dirty = 1'b1;
        seen = 1'b0;
        for (int c = 1; c <= 10 && !seen; c++) begin
            @(negedge clk);
            if (dn_write) seen = 1'b1;
        end
        check("rstwb_dn_write_seen", seen, 1'b1);
        reset_n = 1'b0; up_write = 1'b0; dn_resp = 1'b1;
        @(negedge clk);
        dn_resp = 1'b0;
        check("rstwb_dn_write_drop", dn_write, 1'b0);
        check("rstwb_dn_address", dn_address, {ADDR_W{1'b0}});
        check("rstwb_up_resp", up_resp, 1'b0);
        reset_n = 1'b1;
        model_reset();
        txn(0, 0, 16'h0A00, '0, 0, 2, rnd_line());
        txn(1, 0, 16'h0B00, rnd_line(), 1, 1, '0);

        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 19);
            a  = ADDR_W'(16'h0100 + 16'h0010 * $urandom_range(0, 11));
            if (op == 0) begin
                do_flush(0);
            end else if (op == 1) begin
                txn(1, 1, a, rnd_line(), 1'($urandom_range(0, 1)), $urandom_range(1, 4), '0);
                txn(0, 0, a, '0, 0, 1, '0);
            end else if (op < 9) begin
                txn(0, 0, a, '0, 0, $urandom_range(1, 4), rnd_line());
            end else begin
                txn(1, 0, a, rnd_line(), 1'($urandom_range(0, 1)), $urandom_range(1, 4), '0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
